rl_action_issuer: RTL and testbench

RL_ACTION_ISSUER -- requirements
Module: rl_action_issuer

---
 rtl/rl_action_issuer_if.sv | 69 ++++++
 rtl/rl_action_issuer.sv | 127 ++++++++++++
 tb/tb_rl_action_issuer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rl_action_issuer_if.sv
// Handshake bundle for rl_action_issuer: Q-pair input, operand
// streams to the comparator, comparator result and action output.
interface rl_action_issuer_if #(
  parameter int W = 16
);
  logic [W-1:0] in_q0_tdata;
  logic [W-1:0] in_q1_tdata;
  logic         in_tvalid;
  logic         in_tready;
  logic [W-1:0] m_axis_a_tdata;
  logic         m_axis_a_tvalid;
  logic         m_axis_a_tready;
  logic [W-1:0] m_axis_b_tdata;
  logic         m_axis_b_tvalid;
  logic         m_axis_b_tready;
  logic         cmp_tvalid;
  logic         cmp_index;
  logic         cmp_equal;
  logic         act_tdata;
  logic         act_tie;
  logic         act_tvalid;
  logic         act_tready;
  logic         err_timeout;
  logic         err_stray;

  modport master (
    input  in_q0_tdata,
    input  in_q1_tdata,
    input  in_tvalid,
    output in_tready,
    output m_axis_a_tdata,
    output m_axis_a_tvalid,
    input  m_axis_a_tready,
    output m_axis_b_tdata,
    output m_axis_b_tvalid,
    input  m_axis_b_tready,
    input  cmp_tvalid,
    input  cmp_index,
    input  cmp_equal,
    output act_tdata,
    output act_tie,
    output act_tvalid,
    input  act_tready,
    output err_timeout,
    output err_stray
  );

  modport slave (
    output in_q0_tdata,
    output in_q1_tdata,
    output in_tvalid,
    input  in_tready,
    input  m_axis_a_tdata,
    input  m_axis_a_tvalid,
    output m_axis_a_tready,
    input  m_axis_b_tdata,
    input  m_axis_b_tvalid,
    output m_axis_b_tready,
    output cmp_tvalid,
    output cmp_index,
    output cmp_equal,
    input  act_tdata,
    input  act_tie,
    input  act_tvalid,
    output act_tready,
    input  err_timeout,
    input  err_stray
  );
endinterface

// File: rtl/rl_action_issuer.sv
// Issues a Q-value pair to an external comparator, waits for the
// result and emits the greedy action with alternating tie-break.
module rl_action_issuer #(
  parameter int EXP     = 5,
  parameter int FRA     = 10,
  parameter int TIMEOUT = 64
) (
  input logic                aclk,
  input logic                aresetn,
  rl_action_issuer_if.master bus
);
  localparam int W = EXP + FRA + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

  state_e       state_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         a_pend_q;
  logic         b_pend_q;
  logic [7:0]   cnt_q;
  logic         tie_tgl_q;
  logic         in_tready_q;
  logic         act_tdata_q;
  logic         act_tie_q;
  logic         act_tvalid_q;
  logic         err_to_q;
  logic         err_stray_q;

  logic a_fire;
  logic b_fire;
  logic a_done;
  logic b_done;

  always_comb begin
    a_fire = a_pend_q && bus.m_axis_a_tready;
    b_fire = b_pend_q && bus.m_axis_b_tready;
    a_done = !a_pend_q || a_fire;
    b_done = !b_pend_q || b_fire;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      a_pend_q     <= 1'b0;
      b_pend_q     <= 1'b0;
      cnt_q        <= '0;
      tie_tgl_q    <= 1'b0;
      in_tready_q  <= 1'b1;
      act_tdata_q  <= 1'b0;
      act_tie_q    <= 1'b0;
      act_tvalid_q <= 1'b0;
      err_to_q     <= 1'b0;
      err_stray_q  <= 1'b0;
    end else begin
      if (bus.cmp_tvalid && state_q != S_WAIT)
        err_stray_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_tvalid) begin
            a_q         <= bus.in_q0_tdata;
            b_q         <= bus.in_q1_tdata;
            a_pend_q    <= 1'b1;
            b_pend_q    <= 1'b1;
            in_tready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (a_fire) a_pend_q <= 1'b0;
          if (b_fire) b_pend_q <= 1'b0;
          if (a_done && b_done) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.cmp_tvalid) begin
            // a tie alternates the action so neither side is starved
            act_tvalid_q <= 1'b1;
            act_tie_q    <= bus.cmp_equal;
            act_tdata_q  <= bus.cmp_equal ? tie_tgl_q
                                          : ~bus.cmp_index;
            if (bus.cmp_equal)
              tie_tgl_q <= ~tie_tgl_q;
            state_q <= S_OUT;
          end else if (cnt_q == TMO_LAST) begin
            err_to_q     <= 1'b1;
            act_tvalid_q <= 1'b1;
            act_tie_q    <= 1'b0;
            act_tdata_q  <= 1'b0;
            state_q      <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_OUT: begin
          if (bus.act_tready) begin
            act_tvalid_q <= 1'b0;
            in_tready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_tready       = in_tready_q;
  assign bus.m_axis_a_tdata  = a_q;
  assign bus.m_axis_a_tvalid = a_pend_q;
  assign bus.m_axis_b_tdata  = b_q;
  assign bus.m_axis_b_tvalid = b_pend_q;
  assign bus.act_tdata       = act_tdata_q;
  assign bus.act_tie         = act_tie_q;
  assign bus.act_tvalid      = act_tvalid_q;
  assign bus.err_timeout     = err_to_q;
  assign bus.err_stray       = err_stray_q;
endmodule

// File: tb/tb_rl_action_issuer.sv
// Randomized and directed bench for rl_action_issuer against a
// transaction-level model of action selection and error flags.
module tb_rl_action_issuer;
  localparam int EXP = 5;
  localparam int FRA = 10;
  localparam int W   = EXP + FRA + 1;
  localparam int TMO = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  bit   exp_to;
  bit   exp_stray;
  int   n_ties;

  rl_action_issuer_if #(.W(W)) bus ();

  rl_action_issuer #(
    .EXP(EXP),
    .FRA(FRA),
    .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    check("err_to", bus.err_timeout, exp_to);
    check("err_stray", bus.err_stray, exp_stray);
  endtask

  task automatic run_txn(input logic [W-1:0] q0,
                         input logic [W-1:0] q1,
                         input int sa, input int sb,
                         input int r,
                         input bit eq, input bit idx,
                         input bit nocmp, input bit stray_out,
                         input int os);
    int   acc, lim, last;
    bit   to, done;
    logic ea, et;
    lim = 0;
    while (!bus.in_tready && lim < 20) begin
      tick();
      lim++;
    end
    check("in_rdy", bus.in_tready, 1);
    bus.in_q0_tdata = q0;
    bus.in_q1_tdata = q1;
    bus.in_tvalid = 1'b1;
    tick();
    acc = cyc;
    bus.in_tvalid = 1'b0;
    bus.in_q0_tdata = W'($urandom);
    bus.in_q1_tdata = W'($urandom);
    check("busy", bus.in_tready, 0);
    last = (sa > sb) ? sa : sb;
    for (int k = 0; k <= last; k++) begin
      check("a_vld", bus.m_axis_a_tvalid, k <= sa);
      check("b_vld", bus.m_axis_b_tvalid, k <= sb);
      if (k <= sa) check("a_dat", bus.m_axis_a_tdata, q0);
      if (k <= sb) check("b_dat", bus.m_axis_b_tdata, q1);
      bus.m_axis_a_tready = (k >= sa);
      bus.m_axis_b_tready = (k >= sb);
      tick();
    end
    bus.m_axis_a_tready = 1'b0;
    bus.m_axis_b_tready = 1'b0;
    check("ab_idle", {bus.m_axis_a_tvalid, bus.m_axis_b_tvalid}, 0);
    to = nocmp || (r > TMO);
    done = 1'b0;
    for (int c = 1; c <= TMO + 2 && !done; c++) begin
      bus.cmp_tvalid = !nocmp && (c == r);
      bus.cmp_index = idx;
      bus.cmp_equal = eq;
      tick();
      bus.cmp_tvalid = 1'b0;
      bus.cmp_index = 1'($urandom);
      bus.cmp_equal = 1'($urandom);
      done = bus.act_tvalid;
    end
    check("act_vld", bus.act_tvalid, 1);
    check("latency", cyc - acc, 1 + last + (to ? TMO : r));
    if (to) begin
      ea = 1'b0;
      et = 1'b0;
      exp_to = 1'b1;
    end else if (eq) begin
      ea = n_ties[0];
      et = 1'b1;
      n_ties++;
    end else begin
      ea = ~idx;
      et = 1'b0;
    end
    check("act", bus.act_tdata, ea);
    check("tie", bus.act_tie, et);
    chk_flags();
    for (int s = 0; s < os; s++) begin
      bus.act_tready = 1'b0;
      bus.cmp_tvalid = stray_out && (s == 0);
      tick();
      bus.cmp_tvalid = 1'b0;
      if (stray_out) exp_stray = 1'b1;
      check("hold_vld", bus.act_tvalid, 1);
      check("hold_act", bus.act_tdata, ea);
      check("hold_tie", bus.act_tie, et);
    end
    bus.act_tready = 1'b1;
    tick();
    bus.act_tready = 1'b0;
    check("act_drop", bus.act_tvalid, 0);
    check("in_rdy_back", bus.in_tready, 1);
    chk_flags();
  endtask

  initial begin
    bus.in_q0_tdata = '0;
    bus.in_q1_tdata = '0;
    bus.in_tvalid = 1'b0;
    bus.m_axis_a_tready = 1'b0;
    bus.m_axis_b_tready = 1'b0;
    bus.cmp_tvalid = 1'b0;
    bus.cmp_index = 1'b0;
    bus.cmp_equal = 1'b0;
    bus.act_tready = 1'b0;
    exp_to = 1'b0;
    exp_stray = 1'b0;
    n_ties = 0;

    #12;
    check("rst_in_rdy", bus.in_tready, 1);
    check("rst_vld", {bus.m_axis_a_tvalid, bus.m_axis_b_tvalid,
                      bus.act_tvalid}, 0);
    check("rst_act", {bus.act_tdata, bus.act_tie}, 0);
    chk_flags();
    #10;
    aresetn = 1'b1;
    tick();

    // basic
    run_txn(16'h3C00, 16'h4000, 0, 0, 5, 0, 0, 0, 0, 0);
    // back-pressure on B
    run_txn(16'h1234, 16'h5678, 0, 3, 2, 0, 1, 0, 0, 1);
    // consecutive ties, second one held
    run_txn(16'h4000, 16'h4000, 0, 0, 3, 1, 1, 0, 0, 0);
    run_txn(16'h4400, 16'h4400, 1, 0, 2, 1, 0, 0, 0, 2);
    // timeout, then a normal pair keeps the sticky flag
    run_txn(16'h0001, 16'h0002, 0, 0, 1, 0, 0, 1, 0, 0);
    run_txn(16'h7BFF, 16'h0400, 0, 0, 1, 0, 1, 0, 0, 0);
    // stray result in IDLE
    bus.cmp_tvalid = 1'b1;
    tick();
    bus.cmp_tvalid = 1'b0;
    exp_stray = 1'b1;
    check("stray_idle", bus.err_stray, 1);
    check("stray_noact", bus.act_tvalid, 0);
    // result in the very cycle the counter runs out
    run_txn(16'h2222, 16'h3333, 2, 1, TMO, 0, 0, 0, 0, 0);
    // result too late: timeout, then a stray in OUT
    run_txn(16'h2222, 16'h3333, 0, 0, TMO + 1, 0, 0, 0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      int os;
      os = $urandom_range(0, 3);
      run_txn(W'($urandom), W'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, TMO),
              $urandom_range(0, 3) == 0, 1'($urandom),
              $urandom_range(0, 9) == 0,
              (os > 0) && ($urandom_range(0, 7) == 0), os);
    end

    // reset in the middle of WAIT
    bus.in_q0_tdata = 16'hAAAA;
    bus.in_q1_tdata = 16'h5555;
    bus.in_tvalid = 1'b1;
    tick();
    bus.in_tvalid = 1'b0;
    bus.m_axis_a_tready = 1'b1;
    bus.m_axis_b_tready = 1'b1;
    tick();
    bus.m_axis_a_tready = 1'b0;
    bus.m_axis_b_tready = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    exp_to = 1'b0;
    exp_stray = 1'b0;
    n_ties = 0;
    check("mr_in_rdy", bus.in_tready, 1);
    check("mr_vld", {bus.m_axis_a_tvalid, bus.m_axis_b_tvalid,
                     bus.act_tvalid}, 0);
    check("mr_act", {bus.act_tdata, bus.act_tie}, 0);
    chk_flags();
    #2;
    aresetn = 1'b1;
    bus.cmp_tvalid = 1'b1;
    bus.cmp_equal = 1'b0;
    bus.cmp_index = 1'b0;
    tick();
    bus.cmp_tvalid = 1'b0;
    exp_stray = 1'b1;
    check("post_rst_stray", bus.err_stray, 1);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_noact", bus.act_tvalid, 0);
      tick();
    end
    // tie toggle restarts at 0 after reset
    run_txn(16'h3C00, 16'h3C00, 0, 0, 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
